// File: rtl/ahb_apb_bridge.sv
// AHB-Lite slave that turns each AHB single transfer into one APB3 SETUP/ACCESS pair.
// Optional feature macro APB_TIMEOUT_EN: abort an ACCESS phase stalled for TIMEOUT_CYCLES with an AHB ERROR.
module ahb_apb_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int PADDR_WIDTH    = 16,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic                   HSEL,
    input  logic [ADDR_WIDTH-1:0]  HADDR,
    input  logic                   HWRITE,
    input  logic [2:0]             HSIZE,
    input  logic [2:0]             HBURST,
    input  logic [3:0]             HPROT,
    input  logic [1:0]             HTRANS,
    input  logic                   HLOCK,
    input  logic                   HREADY,
    input  logic [DATA_WIDTH-1:0]  HWDATA,
    output logic                   HREADYOUT,
    output logic                   HRESP,
    output logic [DATA_WIDTH-1:0]  HRDATA,
    output logic                   PSEL,
    output logic                   PENABLE,
    output logic [PADDR_WIDTH-1:0] PADDR,
    output logic                   PWRITE,
    output logic [DATA_WIDTH-1:0]  PWDATA,
    input  logic [DATA_WIDTH-1:0]  PRDATA,
    input  logic                   PREADY,
    input  logic                   PSLVERR
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERR1   = 3'd4,
        ST_ERR2   = 3'd5
    } state_t;

    state_t                 state_reg;
    state_t                 state_next;
    logic [PADDR_WIDTH-1:0] paddr_reg;
    logic                   pwrite_reg;
    logic [DATA_WIDTH-1:0]  pwdata_reg;
    logic [DATA_WIDTH-1:0]  hrdata_reg;
    logic                   xfer_valid;
    logic                   addr_accept;
    logic                   tmo_hit;
    logic                   unused_inputs;

    // Sideband attributes carry no meaning for a word-only, single-beat APB target.
    assign unused_inputs = ^{HSIZE, HBURST, HPROT, HLOCK, HTRANS[0],
                             HADDR[ADDR_WIDTH-1:PADDR_WIDTH]};

    assign xfer_valid  = HSEL & HREADY & HTRANS[1];
    // A new address is only taken in the states that drive HREADYOUT high.
    assign addr_accept = xfer_valid &&
                         ((state_reg == ST_IDLE) || (state_reg == ST_DONE) ||
                          (state_reg == ST_ERR2));

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_WIDTH = (CNT_W_RAW > 8) ? CNT_W_RAW : 8;

    logic [CNT_WIDTH-1:0] tmo_cnt_reg;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            tmo_cnt_reg <= '0;
        end else if (state_reg != ST_ACCESS) begin
            tmo_cnt_reg <= '0;
        end else if (!PREADY) begin
            tmo_cnt_reg <= tmo_cnt_reg + CNT_WIDTH'(1);
        end
    end

    // This stalled cycle is the one that brings the count up to TIMEOUT_CYCLES.
    assign tmo_hit = (tmo_cnt_reg == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (xfer_valid) begin
                    state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                // A PREADY in the timeout cycle still completes normally.
                if (PREADY) begin
                    state_next = PSLVERR ? ST_ERR1 : ST_DONE;
                end else if (tmo_hit) begin
                    state_next = ST_ERR1;
                end
            end
            ST_DONE, ST_ERR2: begin
                state_next = xfer_valid ? ST_SETUP : ST_IDLE;
            end
            ST_ERR1: begin
                state_next = ST_ERR2;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            paddr_reg  <= '0;
            pwrite_reg <= 1'b0;
            pwdata_reg <= '0;
            hrdata_reg <= '0;
        end else begin
            if (addr_accept) begin
                paddr_reg  <= HADDR[PADDR_WIDTH-1:0];
                pwrite_reg <= HWRITE;
            end
            if (state_reg == ST_SETUP) begin
                pwdata_reg <= HWDATA;
            end
            if ((state_reg == ST_ACCESS) && PREADY && !PSLVERR && !pwrite_reg) begin
                hrdata_reg <= PRDATA;
            end
        end
    end

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        PWDATA    = pwdata_reg;
        case (state_reg)
            ST_SETUP: begin
                HREADYOUT = 1'b0;
                PSEL      = 1'b1;
                // HWDATA is only valid now, so it is passed straight through.
                PWDATA    = HWDATA;
            end
            ST_ACCESS: begin
                HREADYOUT = 1'b0;
                PSEL      = 1'b1;
                PENABLE   = 1'b1;
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            ST_ERR2: begin
                HRESP     = 1'b1;
            end
            default: begin
                HREADYOUT = 1'b1;
            end
        endcase
    end

    assign PADDR  = paddr_reg;
    assign PWRITE = pwrite_reg;
    assign HRDATA = hrdata_reg;

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Scoreboard bench for ahb_apb_bridge: stimulus queues expected AHB/APB responses, monitors compare.
module tb_ahb_apb_bridge;

    logic        HCLK;
    logic        HRESET;
    logic        HSEL;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HLOCK;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic        PSEL;
    logic        PENABLE;
    logic [15:0] PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic        resp;
        logic [31:0] rdata;
        int          waits;
    } ahb_exp_t;

    typedef struct {
        logic [15:0] paddr;
        logic        wr;
        logic [31:0] wdata;
    } apb_exp_t;

    ahb_exp_t    ahb_q[$];
    apb_exp_t    apb_q[$];
    int          tests = 0;
    int          fails = 0;
    int          slv_waits = 0;
    logic        slv_err = 1'b0;
    logic [31:0] slv_rdata = 32'h0;
    logic [31:0] model_hrdata = 32'h0;

    ahb_apb_bridge dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HPROT     (HPROT),
        .HTRANS    (HTRANS),
        .HLOCK     (HLOCK),
        .HREADY    (HREADY),
        .HWDATA    (HWDATA),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PADDR     (PADDR),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    // Only slave on the bus, so the bus HREADY is our own HREADYOUT.
    assign HREADY = HREADYOUT;

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // AHB data-phase monitor: pops one expectation per completed transfer.
    initial begin : ahb_monitor
        bit       dphase;
        bit       addr_now;
        int       waits;
        ahb_exp_t e;
        dphase = 1'b0;
        waits  = 0;
        forever begin
            @(negedge HCLK);
            if (HRESET) begin
                dphase = 1'b0;
                waits  = 0;
            end else begin
                addr_now = HSEL && HREADYOUT && HTRANS[1];
                if (dphase && !HREADYOUT) begin
                    waits++;
                end else begin
                    if (dphase) begin
                        if (ahb_q.size() == 0) begin
                            tests++;
                            fails++;
                            $display("FAIL ahb_unexpected: got a completed transfer, required none");
                        end else begin
                            e = ahb_q.pop_front();
                            chk("ahb_hresp", HRESP, e.resp);
                            chk("ahb_hrdata", HRDATA, e.rdata);
                            chk("ahb_waits", waits, e.waits);
                            $display("[TB] ahb %s addr=0x%08h hresp=%0b hrdata=0x%08h waits=%0d",
                                     e.wr ? "WR" : "RD", e.addr, HRESP, HRDATA, waits);
                        end
                    end
                    dphase = addr_now;
                    waits  = 0;
                end
            end
        end
    end

    // APB slave model plus APB-side scoreboard check at each completed ACCESS.
    initial begin : apb_slave
        int       acc;
        apb_exp_t a;
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        PRDATA  = 32'h0;
        acc     = 0;
        forever begin
            @(negedge HCLK);
            if (PSEL && PENABLE) begin
                PREADY  = (acc >= slv_waits);
                PSLVERR = PREADY && slv_err;
                PRDATA  = PREADY ? slv_rdata : 32'h0;
                if (!PREADY) begin
                    acc++;
                end else if (apb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL apb_unexpected: got APB access at 0x%04h, required none", PADDR);
                end else begin
                    a = apb_q.pop_front();
                    chk("apb_paddr", PADDR, a.paddr);
                    chk("apb_pwrite", PWRITE, a.wr);
                    if (a.wr) chk("apb_pwdata", PWDATA, a.wdata);
                end
            end else begin
                PREADY  = 1'b0;
                PSLVERR = 1'b0;
                acc     = 0;
            end
        end
    end

    task automatic issue(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                         input int swaits, input logic serr, input logic [31:0] srdata,
                         input logic exp_resp, input int exp_waits, input bit push_apb);
        int       n = 0;
        ahb_exp_t e;
        apb_exp_t a;
        @(posedge HCLK); #1;
        while (!HREADYOUT && n < 200) begin
            @(posedge HCLK); #1;
            n++;
        end
        if (!HREADYOUT) begin
            tests++;
            fails++;
            $display("FAIL bus_ready_timeout: HREADYOUT=%0b required 1", HREADYOUT);
        end
        slv_waits = swaits;
        slv_err   = serr;
        slv_rdata = srdata;
        if (!wr && !exp_resp) model_hrdata = srdata;
        e = '{addr, wr, exp_resp, model_hrdata, exp_waits};
        ahb_q.push_back(e);
        if (push_apb) begin
            a = '{addr[15:0], wr, wdata};
            apb_q.push_back(a);
        end
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HADDR  = addr;
        HWRITE = wr;
        @(posedge HCLK); #1;
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWDATA = wdata;
    endtask

    initial begin : stimulus
        int n_acc;
        HRESET = 1'b1;
        HSEL   = 1'b0;
        HADDR  = 32'h0;
        HWRITE = 1'b0;
        HSIZE  = 3'b010;
        HBURST = 3'b000;
        HPROT  = 4'b0011;
        HTRANS = 2'b00;
        HLOCK  = 1'b0;
        HWDATA = 32'h0;
        repeat (3) @(posedge HCLK);
        #1 HRESET = 1'b0;

        chk("rst_hreadyout", HREADYOUT, 1'b1);
        chk("rst_hresp", HRESP, 1'b0);
        chk("rst_psel", PSEL, 1'b0);
        chk("rst_penable", PENABLE, 1'b0);
        chk("rst_paddr", PADDR, 16'h0);
        chk("rst_pwrite", PWRITE, 1'b0);
        chk("rst_pwdata", PWDATA, 32'h0);
        chk("rst_hrdata", HRDATA, 32'h0);

        // IDLE and BUSY transfers: zero-wait OKAY, no APB activity.
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b00; HADDR = 32'h100;
        @(posedge HCLK); #1;
        HTRANS = 2'b01;
        @(negedge HCLK);
        chk("idle_hreadyout", HREADYOUT, 1'b1);
        chk("idle_psel", PSEL, 1'b0);
        @(posedge HCLK); #1;
        @(negedge HCLK);
        chk("busy_hreadyout", HREADYOUT, 1'b1);
        chk("busy_hresp", HRESP, 1'b0);
        chk("busy_psel", PSEL, 1'b0);
        HSEL = 1'b0; HTRANS = 2'b00;

        // Write with PREADY high: SETUP then ACCESS, PWDATA held from register.
        issue(32'h0000_1234, 1'b1, 32'hDEAD_BEEF, 0, 1'b0, 32'h0, 1'b0, 2, 1'b1);
        @(negedge HCLK);
        chk("wr_setup_psel", PSEL, 1'b1);
        chk("wr_setup_penable", PENABLE, 1'b0);
        chk("wr_setup_pwdata", PWDATA, 32'hDEAD_BEEF);
        chk("wr_setup_paddr", PADDR, 16'h1234);
        @(posedge HCLK); #1;
        HWDATA = 32'h0;
        @(negedge HCLK);
        chk("wr_access_psel", PSEL, 1'b1);
        chk("wr_access_penable", PENABLE, 1'b1);
        chk("wr_access_pwdata", PWDATA, 32'hDEAD_BEEF);

        // Read with three PREADY-low cycles: five wait states.
        issue(32'h0000_0040, 1'b0, 32'h0, 3, 1'b0, 32'hA5A5_0F0F, 1'b0, 5, 1'b1);

        // Slave error: ERR1 then ERR2, then IDLE OKAY.
        issue(32'h0000_0080, 1'b1, 32'h0BAD_0BAD, 0, 1'b1, 32'h0, 1'b1, 3, 1'b1);
        @(negedge HCLK);
        @(negedge HCLK);
        @(negedge HCLK);
        chk("err1_hreadyout", HREADYOUT, 1'b0);
        chk("err1_hresp", HRESP, 1'b1);
        chk("err1_psel", PSEL, 1'b0);
        @(negedge HCLK);
        chk("err2_hreadyout", HREADYOUT, 1'b1);
        chk("err2_hresp", HRESP, 1'b1);
        @(negedge HCLK);
        chk("post_err_hreadyout", HREADYOUT, 1'b1);
        chk("post_err_hresp", HRESP, 1'b0);

        // Back-to-back reads: second address taken in DONE.
        issue(32'h0000_0010, 1'b0, 32'h0, 0, 1'b0, 32'h1111_1111, 1'b0, 2, 1'b1);
        issue(32'h0000_0014, 1'b0, 32'h0, 0, 1'b0, 32'h2222_2222, 1'b0, 2, 1'b1);
        @(negedge HCLK);
        chk("b2b_setup_psel", PSEL, 1'b1);
        chk("b2b_setup_penable", PENABLE, 1'b0);
        chk("b2b_setup_paddr", PADDR, 16'h0014);

`ifdef APB_TIMEOUT_EN
        // Stalled slave: 16 ACCESS cycles, then ERR1/ERR2.
        issue(32'h0000_0020, 1'b0, 32'h0, 1000, 1'b0, 32'h0, 1'b1, 18, 1'b0);
        n_acc = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge HCLK);
            if (PSEL && PENABLE) n_acc++;
            else if (n_acc > 0) break;
        end
        chk("tmo_access_cycles", n_acc, 16);
        chk("tmo_psel", PSEL, 1'b0);
        chk("tmo_hresp", HRESP, 1'b1);
        issue(32'h0000_0024, 1'b0, 32'h5555_AAAA, 1000, 1'b0, 32'h0, 1'b0, 0, 1'b0);
`else
        // Stalled slave without timeout: ACCESS holds indefinitely.
        issue(32'h0000_0024, 1'b0, 32'h5555_AAAA, 1000, 1'b0, 32'h0, 1'b0, 0, 1'b0);
        n_acc = 0;
        repeat (100) @(negedge HCLK);
        chk("notmo_still_access", {PSEL, PENABLE}, 2'b11);
`endif
        @(negedge HCLK);
        @(negedge HCLK);
        chk("pre_rst_access", {PSEL, PENABLE}, 2'b11);

        // Asynchronous reset in the middle of an ACCESS cycle.
        @(posedge HCLK); #2;
        HRESET = 1'b1;
        #1;
        chk("arst_psel", PSEL, 1'b0);
        chk("arst_penable", PENABLE, 1'b0);
        chk("arst_hreadyout", HREADYOUT, 1'b1);
        chk("arst_hresp", HRESP, 1'b0);
        chk("arst_paddr", PADDR, 16'h0);
        chk("arst_pwdata", PWDATA, 32'h0);
        chk("arst_hrdata", HRDATA, 32'h0);
        ahb_q.delete();
        apb_q.delete();
        model_hrdata = 32'h0;
        slv_waits    = 0;
        @(posedge HCLK); #1;
        HRESET = 1'b0;

        // Normal operation after reset, including PADDR truncation.
        issue(32'h2000_0008, 1'b1, 32'h1234_5678, 0, 1'b0, 32'h0, 1'b0, 2, 1'b1);
        issue(32'h0000_FFFC, 1'b0, 32'h0, 1, 1'b0, 32'hCAFE_F00D, 1'b0, 3, 1'b1);

        for (int i = 0; i < 200; i++) begin
            @(negedge HCLK);
            if (ahb_q.size() == 0 && apb_q.size() == 0) break;
        end
        @(negedge HCLK);
        chk("drain_ahb_q", ahb_q.size(), 0);
        chk("drain_apb_q", apb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
